// File: rtl/vga_fill_engine.sv
// Pixel-write command engine: turns CPU register writes into a row-major stream of
// framebuffer pixel writes (single plot or clipped rectangle fill).
module vga_fill_engine #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wrEn,
  input  logic [2:0]  i_regAddr,
  input  logic [31:0] i_wrData,
  input  logic        i_pxlReady,
  output logic [31:0] o_pxlAddr,
  output logic [31:0] o_pxlData,
  output logic        o_pxlWe,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  localparam logic [16:0] HResW  = 17'(H_RES);
  localparam logic [16:0] VResW  = 17'(V_RES);
  localparam logic [31:0] HRes32 = 32'(H_RES);

  state_e      state_q, state_d;
  logic [15:0] x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [31:0] color_q, color_d;
  logic        single_q, single_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [16:0] x_end_q, x_end_d, y_end_q, y_end_d;
  logic [31:0] row_base_q, row_base_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        we_q, we_d, busy_q, busy_d, done_q, done_d;

  logic [15:0] w_eff, h_eff;
  logic [16:0] x_sum, y_sum, x_end_c, y_end_c, x_inc, y_inc;
  logic [31:0] setup_base;
  logic        empty;

  // Clip against the visible area with 17-bit sums so X0+W cannot wrap.
  always_comb begin
    w_eff      = single_q ? 16'd1 : w_q;
    h_eff      = single_q ? 16'd1 : h_q;
    x_sum      = {1'b0, x0_q} + {1'b0, w_eff};
    y_sum      = {1'b0, y0_q} + {1'b0, h_eff};
    x_end_c    = (x_sum > HResW) ? HResW : x_sum;
    y_end_c    = (y_sum > VResW) ? VResW : y_sum;
    empty      = ({1'b0, x0_q} >= HResW) || ({1'b0, y0_q} >= VResW) ||
                 (w_eff == 16'd0) || (h_eff == 16'd0);
    setup_base = BASE_ADDR + 32'(y0_q) * HRes32;
    x_inc      = {1'b0, x_q} + 17'd1;
    y_inc      = {1'b0, y_q} + 17'd1;
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    single_d   = single_q;
    x_d        = x_q;
    y_d        = y_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_wrEn) begin
          case (i_regAddr)
            3'd0: x0_d    = i_wrData[15:0];
            3'd1: y0_d    = i_wrData[15:0];
            3'd2: w_d     = i_wrData[15:0];
            3'd3: h_d     = i_wrData[15:0];
            3'd4: color_d = i_wrData;
            3'd5: begin
              if (i_wrData[1:0] == 2'd1 || i_wrData[1:0] == 2'd2) begin
                single_d = (i_wrData[1:0] == 2'd2);
                data_d   = color_q;
                busy_d   = 1'b1;
                state_d  = StSetup;
              end
            end
            default: ;
          endcase
        end
      end
      StSetup: begin
        x_end_d = x_end_c;
        y_end_d = y_end_c;
        if (empty) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          x_d        = x0_q;
          y_d        = y0_q;
          row_base_d = setup_base;
          addr_d     = setup_base + 32'(x0_q);
          we_d       = 1'b1;
          state_d    = StFill;
        end
      end
      StFill: begin
        if (i_pxlReady) begin
          if (x_inc == x_end_q) begin
            x_d        = x0_q;
            y_d        = y_inc[15:0];
            row_base_d = row_base_q + HRes32;
            addr_d     = row_base_q + HRes32 + 32'(x0_q);
            if (y_inc == y_end_q) begin
              we_d    = 1'b0;
              done_d  = 1'b1;
              state_d = StDone;
            end
          end else begin
            x_d    = x_inc[15:0];
            addr_d = addr_q + 32'd1;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      single_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      single_q   <= single_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_pxlAddr = addr_q;
  assign o_pxlData = data_q;
  assign o_pxlWe   = we_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Bench for vga_fill_engine: directed scenarios plus random traffic, checked every
// cycle against a model that precomputes each command's clipped pixel list.
module tb_vga_fill_engine;
  localparam int HR = 640;
  localparam int VR = 480;

  logic        clk = 1'b0;
  logic        rst, wr_en, ready;
  logic [2:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] pxl_addr, pxl_data;
  logic        pxl_we, busy, done;

  always #5 clk = ~clk;

  vga_fill_engine #(.H_RES(HR), .V_RES(VR), .BASE_ADDR(32'h0)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wrEn     (wr_en),
    .i_regAddr  (reg_addr),
    .i_wrData   (wr_data),
    .i_pxlReady (ready),
    .o_pxlAddr  (pxl_addr),
    .o_pxlData  (pxl_data),
    .o_pxlWe    (pxl_we),
    .o_busy     (busy),
    .o_done     (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Model: 0 idle, 1 setup, 2 fill, 3 done; pixel list built up front from the clip rules.
  int          stage = 0;
  int          cyc = 0;
  int          cmd_cyc = 0;
  logic [15:0] m_x0, m_y0, m_w, m_h;
  logic [31:0] m_color, m_lcolor;
  int          beats[$];
  bit          chk_en = 1'b0;

  int          acc_log[$];
  logic [31:0] dat_log[$];
  int          done_log[$];
  int          we_cnt;

  task automatic build(input bit single);
    int w, h;
    w = single ? 1 : int'(m_w);
    h = single ? 1 : int'(m_h);
    beats.delete();
    for (int yy = int'(m_y0); yy < int'(m_y0) + h && yy < VR; yy++)
      for (int xx = int'(m_x0); xx < int'(m_x0) + w && xx < HR; xx++)
        beats.push_back(yy * HR + xx);
    m_lcolor = m_color;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      stage = 0;
      m_x0 = '0; m_y0 = '0; m_w = '0; m_h = '0;
      m_color = '0; m_lcolor = '0;
      beats.delete();
    end else begin
      case (stage)
        0: if (wr_en) begin
          case (reg_addr)
            3'd0: m_x0 = wr_data[15:0];
            3'd1: m_y0 = wr_data[15:0];
            3'd2: m_w = wr_data[15:0];
            3'd3: m_h = wr_data[15:0];
            3'd4: m_color = wr_data;
            3'd5: if (wr_data[1:0] == 2'd1 || wr_data[1:0] == 2'd2) begin
              build(wr_data[1:0] == 2'd2);
              stage = 1;
              cmd_cyc = cyc;
            end
            default: ;
          endcase
        end
        1: stage = (beats.size() == 0) ? 3 : 2;
        2: if (ready) begin
          void'(beats.pop_front());
          if (beats.size() == 0) stage = 3;
        end
        default: stage = 0;
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, stage != 0});
      check("done", {31'b0, done}, {31'b0, stage == 3});
      check("we", {31'b0, pxl_we}, {31'b0, stage == 2});
      if (stage == 2 && beats.size() > 0) begin
        check("addr", pxl_addr, 32'(beats[0]));
        check("data", pxl_data, m_lcolor);
      end
      if (pxl_we) we_cnt++;
      if (pxl_we && ready && !rst) begin
        acc_log.push_back(int'(pxl_addr));
        dat_log.push_back(pxl_data);
      end
      if (done) done_log.push_back(cyc - cmd_cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; reg_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic clear_logs();
    acc_log.delete(); dat_log.delete(); done_log.delete(); we_cnt = 0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while ((busy || stage != 0) && k < max) begin
      step(1);
      k++;
    end
    check("idle_timeout", {31'b0, k < max}, 32'd1);
  endtask

  int exp1[6] = '{642, 643, 644, 1282, 1283, 1284};

  initial begin
    rst = 1'b1; wr_en = 1'b0; reg_addr = '0; wr_data = '0; ready = 1'b1;
    step(2);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    check("rst_addr", pxl_addr, 32'd0);
    check("rst_data", pxl_data, 32'd0);

    // Basic 3x2 fill
    wr(3'd0, 2); wr(3'd1, 1); wr(3'd2, 3); wr(3'd3, 2); wr(3'd4, 32'hFF00FF00);
    clear_logs();
    wr(3'd5, 1);
    wait_idle(100);
    check("fill_cnt", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
      check("fill_addr", 32'(acc_log[i]), 32'(exp1[i]));
      check("fill_data", dat_log[i], 32'hFF00FF00);
    end
    check("fill_done_n", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) check("fill_done_t", 32'(done_log[0]), 32'd8);

    // Clipped corner
    wr(3'd0, 638); wr(3'd1, 479); wr(3'd2, 10); wr(3'd3, 10);
    clear_logs();
    wr(3'd5, 1);
    wait_idle(100);
    check("clip_cnt", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() >= 2) begin
      check("clip_a0", 32'(acc_log[0]), 32'd307198);
      check("clip_a1", 32'(acc_log[1]), 32'd307199);
    end
    if (done_log.size() > 0) check("clip_done_t", 32'(done_log[0]), 32'd4);

    // Zero width, then off-screen X0
    wr(3'd2, 0);
    clear_logs();
    wr(3'd5, 1);
    wait_idle(20);
    check("zw_we", 32'(we_cnt), 32'd0);
    if (done_log.size() > 0) check("zw_done_t", 32'(done_log[0]), 32'd2);
    check("zw_done_n", 32'(done_log.size()), 32'd1);
    wr(3'd2, 3); wr(3'd0, 640);
    clear_logs();
    wr(3'd5, 1);
    wait_idle(20);
    check("off_we", 32'(we_cnt), 32'd0);
    if (done_log.size() > 0) check("off_done_t", 32'(done_log[0]), 32'd2);

    // Single pixel with backpressure
    wr(3'd0, 5); wr(3'd1, 0);
    ready = 1'b0;
    clear_logs();
    wr(3'd5, 2);
    step(5);
    ready = 1'b1;
    wait_idle(20);
    check("bp_we_cycles", 32'(we_cnt), 32'd5);
    check("bp_cnt", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() > 0) check("bp_addr", 32'(acc_log[0]), 32'd5);
    if (done_log.size() > 0) check("bp_done_t", 32'(done_log[0]), 32'd7);

    // Writes during a busy 4x4 fill are ignored
    wr(3'd0, 0); wr(3'd1, 0); wr(3'd2, 4); wr(3'd3, 4); wr(3'd4, 32'hABCD1234);
    clear_logs();
    wr(3'd5, 1);
    step(2);
    wr(3'd4, 32'h1);
    wr(3'd5, 1);
    wait_idle(100);
    check("lock_cnt", 32'(acc_log.size()), 32'd16);
    if (dat_log.size() == 16) check("lock_data15", dat_log[15], 32'hABCD1234);
    check("lock_done_n", 32'(done_log.size()), 32'd1);

    // Reset after 3 of 16 beats
    clear_logs();
    wr(3'd5, 1);
    step(4);
    rst = 1'b1; ready = 1'b0;
    step(1);
    rst = 1'b0; ready = 1'b1;
    check("abort_we", {31'b0, pxl_we}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_cnt", 32'(acc_log.size()), 32'd3);
    step(3);
    check("abort_done_n", 32'(done_log.size()), 32'd0);
    clear_logs();
    wr(3'd5, 1);
    wait_idle(20);
    check("post_rst_zero", 32'(we_cnt), 32'd0);
    wr(3'd2, 1); wr(3'd3, 1);
    clear_logs();
    wr(3'd5, 1);
    wait_idle(20);
    check("post_rst_cnt", 32'(acc_log.size()), 32'd1);
    if (dat_log.size() > 0) check("post_rst_color", dat_log[0], 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      reg_addr = 3'($urandom_range(0, 7));
      case (reg_addr)
        3'd0: wr_data = $urandom_range(0, 699);
        3'd1: wr_data = $urandom_range(0, 499);
        3'd2, 3'd3: wr_data = $urandom_range(0, 8);
        3'd5: wr_data = $urandom_range(0, 3);
        default: wr_data = $urandom;
      endcase
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 599) == 0);
      step(1);
    end
    wr_en = 1'b0; rst = 1'b0; ready = 1'b1;
    wait_idle(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
